// File: rtl/uart_pkg.sv
// uart_pkg: shared UART baud-generation defaults used by the TX/RX datapaths.
package uart_pkg;

  // Default oversample factor (ticks per bit); must be a power of two >= 2.
  localparam int UART_OVS_DEFAULT    = 16;

  // Default widths of the integer and fractional parts of the baud divisor.
  localparam int UART_DIV_W          = 16;
  localparam int UART_FRAC_W         = 4;

  // Divisor after reset: 100 MHz / 115200 / 16 = 54.25 -> 54 + 4/16.
  localparam int UART_RESET_DIV_INT  = 54;
  localparam int UART_RESET_DIV_FRAC = 4;

endpackage

// File: rtl/uart_phase_counter.sv
// uart_phase_counter: modulo-OVS counter with enable and synchronous clear.
// wrap is high while the count sits at its last value (OVS-1), so the caller
// can qualify its own advance strobe with it to find the final phase.
module uart_phase_counter
  import uart_pkg::*;
#(
  parameter int OVS = UART_OVS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clr,
  output logic [$clog2(OVS)-1:0] phase,
  output logic                   wrap
);

  localparam int PH_W = $clog2(OVS);

  assign wrap = (phase == PH_W'(OVS - 1));

  // Phase register: clear wins over advance, and it wraps OVS-1 -> 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= wrap ? '0 : phase + PH_W'(1);
    end
  end

endmodule

// File: rtl/uart_frac_baud_gen.sv
// uart_frac_baud_gen: fractional baud tick generator. Produces an oversample
// tick every div_int (+1 when the fractional accumulator carries) enabled
// clocks, and a bit tick on every OVS-th oversample tick. New divisors are
// held in a shadow register and only take effect at an interval boundary.
module uart_frac_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W          = UART_DIV_W,
  parameter int FRAC_W         = UART_FRAC_W,
  parameter int OVS            = UART_OVS_DEFAULT,
  parameter int RESET_DIV_INT  = UART_RESET_DIV_INT,
  parameter int RESET_DIV_FRAC = UART_RESET_DIV_FRAC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ena,
  input  logic [DIV_W-1:0]       div_int,
  input  logic [FRAC_W-1:0]      div_frac,
  input  logic                   div_load,
  input  logic                   sync_clr,
  output logic                   os_tick,
  output logic                   bit_tick,
  output logic [$clog2(OVS)-1:0] os_phase,
  output logic                   cfg_err
);

  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic [DIV_W-1:0]  div_int_act;
  logic [FRAC_W-1:0] frac_act;
  logic [DIV_W-1:0]  div_int_pend;
  logic [FRAC_W-1:0] frac_pend;
  logic              pend_valid;

  logic [FRAC_W:0]   acc_sum;
  logic              ext;
  logic [DIV_W:0]    limit;
  logic              terminal;
  logic              load_ok;
  logic              load_bad;
  logic              apply_pend;
  logic              phase_wrap;

  // The carry out of the fractional accumulator stretches this interval by one clock.
  assign acc_sum = {1'b0, acc} + {1'b0, frac_act};
  assign ext     = acc_sum[FRAC_W];

  // Last count value of the current interval, computed one bit wider so that
  // div_int_act - 1 + ext can never wrap.
  assign limit = {1'b0, div_int_act} - (DIV_W + 1)'(1) + (DIV_W + 1)'(ext);

  // >= rather than == so that a smaller divisor applied while ena is low
  // cannot leave cnt stranded above the new limit.
  assign terminal = ({1'b0, cnt} >= limit);

  assign os_tick  = ena & terminal & ~sync_clr & ~reset;
  assign bit_tick = os_tick & phase_wrap;

  assign load_ok  = div_load & (div_int != '0);
  assign load_bad = div_load & (div_int == '0);

  // A pending divisor is taken at the end of the running interval, or
  // straight away while counting is paused (nothing is in flight then).
  assign apply_pend = pend_valid & (~ena | terminal);

  // Cycle counter and fractional accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
    end else if (sync_clr) begin
      cnt <= '0;
      acc <= '0;
    end else if (!ena) begin
      if (apply_pend) begin
        acc <= '0;
      end
    end else if (terminal) begin
      cnt <= '0;
      acc <= apply_pend ? '0 : acc_sum[FRAC_W-1:0];
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  // Active divisor and its shadow; the shadow keeps reloads glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_int_act  <= DIV_W'(RESET_DIV_INT);
      frac_act     <= FRAC_W'(RESET_DIV_FRAC);
      div_int_pend <= '0;
      frac_pend    <= '0;
      pend_valid   <= 1'b0;
    end else if (sync_clr) begin
      pend_valid <= 1'b0;
      if (load_ok) begin
        div_int_act <= div_int;
        frac_act    <= div_frac;
      end else if (pend_valid) begin
        div_int_act <= div_int_pend;
        frac_act    <= frac_pend;
      end
    end else begin
      if (apply_pend) begin
        div_int_act <= div_int_pend;
        frac_act    <= frac_pend;
        pend_valid  <= 1'b0;
      end
      if (load_ok) begin
        div_int_pend <= div_int;
        frac_pend    <= div_frac;
        pend_valid   <= 1'b1;
      end
    end
  end

  // Sticky configuration error: set by a zero divisor, cleared by a good one.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_err <= 1'b0;
    end else if (load_ok) begin
      cfg_err <= 1'b0;
    end else if (load_bad) begin
      cfg_err <= 1'b1;
    end
  end

  uart_phase_counter #(
    .OVS (OVS)
  ) u_phase (
    .clk   (clk),
    .reset (reset),
    .en    (os_tick),
    .clr   (sync_clr),
    .phase (os_phase),
    .wrap  (phase_wrap)
  );

endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// tb_uart_frac_baud_gen: directed and randomized checks of the fractional
// baud generator against a closed-form tick-time model.
module tb_uart_frac_baud_gen;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OVS    = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ena = 1'b0;
  logic [DIV_W-1:0]  div_int = '0;
  logic [FRAC_W-1:0] div_frac = '0;
  logic              div_load = 1'b0;
  logic              sync_clr = 1'b0;
  logic              os_tick;
  logic              bit_tick;
  logic [3:0]        os_phase;
  logic              cfg_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: the k-th tick after an epoch start (reset, sync_clr or
  // divisor apply, accumulator zero) lands on enabled cycle
  // k*div + floor(k*frac / 2^FRAC_W).
  longint m_elapsed = 0;
  longint m_k = 0;
  int     m_div = 54;
  int     m_frac = 4;
  int     m_pend_div = 0;
  int     m_pend_frac = 0;
  bit     m_pend_valid = 1'b0;
  int     m_phase = 0;
  bit     m_err = 1'b0;
  bit     m_known = 1'b0;
  logic   exp_tick;
  logic   exp_bit;
  logic   seen_tick;
  logic   seen_bit;

  always #5 clk = ~clk;

  uart_frac_baud_gen dut (
    .clk      (clk),
    .reset    (reset),
    .ena      (ena),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .sync_clr (sync_clr),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .os_phase (os_phase),
    .cfg_err  (cfg_err)
  );

  function automatic logic model_tick();
    longint due;
    if (reset || sync_clr || !ena) return 1'b0;
    due = (m_k + 1) * longint'(m_div) + (((m_k + 1) * longint'(m_frac)) >> FRAC_W);
    return (m_elapsed + 1 == due);
  endfunction

  task automatic check1(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("[TB] FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic checkOutput();
    exp_tick = model_tick();
    exp_bit  = exp_tick && (m_phase == OVS - 1);
    check1("os_tick", 32'(os_tick), 32'(exp_tick));
    check1("bit_tick", 32'(bit_tick), 32'(exp_bit));
    if (m_known) begin
      check1("os_phase", 32'(os_phase), 32'(m_phase));
      check1("cfg_err", 32'(cfg_err), 32'(m_err));
    end
  endtask

  task automatic modelUpdate();
    if (reset) begin
      m_elapsed = 0; m_k = 0; m_div = 54; m_frac = 4;
      m_pend_valid = 1'b0; m_phase = 0; m_err = 1'b0; m_known = 1'b1;
      return;
    end
    if (sync_clr) begin
      m_elapsed = 0; m_k = 0; m_phase = 0;
      if (div_load && div_int != 0) begin
        m_div = int'(div_int); m_frac = int'(div_frac);
      end else if (m_pend_valid) begin
        m_div = m_pend_div; m_frac = m_pend_frac;
      end
      m_pend_valid = 1'b0;
    end else begin
      if (ena) begin
        m_elapsed++;
        if (exp_tick) begin
          m_phase = (m_phase + 1) % OVS;
          m_k++;
          if (m_pend_valid) begin
            m_div = m_pend_div; m_frac = m_pend_frac;
            m_elapsed = 0; m_k = 0; m_pend_valid = 1'b0;
          end
        end
      end
      if (div_load && div_int != 0) begin
        m_pend_div = int'(div_int); m_pend_frac = int'(div_frac); m_pend_valid = 1'b1;
      end
    end
    if (div_load) m_err = (div_int == 0);
  endtask

  task automatic applyStimulus(input logic e, input logic l, input logic [DIV_W-1:0] di,
                               input logic [FRAC_W-1:0] df, input logic sc, input logic r);
    ena = e; div_load = l; div_int = di; div_frac = df; sync_clr = sc; reset = r;
    @(negedge clk);
    checkOutput();
    seen_tick = os_tick;
    seen_bit  = bit_tick;
    @(posedge clk);
    modelUpdate();
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic e);
    repeat (n) applyStimulus(e, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // Counts enabled cycles up to and including the next os_tick (bounded).
  task automatic runUntilTick(output int n);
    n = 0;
    do begin
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      n++;
    end while (!seen_tick && n < 2000);
  endtask

  initial begin
    int n;
    int sum;

    // Reset with default divisor, then the 54,54,54,55 pattern and 868 clk per bit.
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    check1("reset_phase", 32'(os_phase), 32'd0);
    check1("reset_cfg_err", 32'(cfg_err), 32'd0);
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      runUntilTick(n);
      sum += n;
      check1("interval_default", 32'(n), (i % 4 == 3) ? 32'd55 : 32'd54);
    end
    check1("bit_tick_16th", 32'(seen_bit), 32'd1);
    check1("clk_per_bit", 32'(sum), 32'd868);

    // Mid-interval load of 3/0: old 54-clk interval completes, then 3-clk ticks.
    idle(10, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'd3, 4'd0, 1'b0, 1'b0);
    runUntilTick(n);
    check1("load_finish_old", 32'(n), 32'd43);
    for (int i = 0; i < 4; i++) begin
      runUntilTick(n);
      check1("interval_3", 32'(n), 32'd3);
    end

    // Zero divisor is rejected; a following 5/0 load clears the error.
    applyStimulus(1'b1, 1'b1, 16'd0, 4'd0, 1'b0, 1'b0);
    check1("cfg_err_set", 32'(cfg_err), 32'd1);
    runUntilTick(n);
    check1("interval_after_bad", 32'(n), 32'd2);
    runUntilTick(n);
    check1("interval_3_kept", 32'(n), 32'd3);
    applyStimulus(1'b1, 1'b1, 16'd5, 4'd0, 1'b0, 1'b0);
    check1("cfg_err_clear", 32'(cfg_err), 32'd0);
    runUntilTick(n);
    check1("interval_old_3", 32'(n), 32'd2);
    for (int i = 0; i < 3; i++) begin
      runUntilTick(n);
      check1("interval_5", 32'(n), 32'd5);
    end

    // Pause at cnt=20 for 10 cycles: tick arrives 34 enabled cycles after resume.
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    runUntilTick(n);
    check1("first_after_reset", 32'(n), 32'd54);
    idle(20, 1'b1);
    idle(10, 1'b0);
    runUntilTick(n);
    check1("resume_after_hold", 32'(n), 32'd34);

    // sync_clr at phase 7, cnt 30: phase to 0 and a full 54-clk interval follows.
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) runUntilTick(n);
    check1("phase_before_clr", 32'(os_phase), 32'd7);
    idle(30, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    check1("phase_after_clr", 32'(os_phase), 32'd0);
    runUntilTick(n);
    check1("interval_after_clr", 32'(n), 32'd54);

    // div 1 + 8/16: intervals alternate 1,2; reset mid-run restores 54.25.
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'd1, 4'd8, 1'b0, 1'b0);
    runUntilTick(n);
    check1("finish_before_1p5", 32'(n), 32'd53);
    for (int i = 0; i < 6; i++) begin
      runUntilTick(n);
      check1("interval_1p5", 32'(n), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    check1("midrun_reset_phase", 32'(os_phase), 32'd0);
    runUntilTick(n);
    check1("after_midrun_reset", 32'(n), 32'd54);
    runUntilTick(n);
    check1("after_midrun_reset2", 32'(n), 32'd54);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic r, e, l, s;
      logic [DIV_W-1:0]  d;
      logic [FRAC_W-1:0] f;
      r = ($urandom_range(0, 599) == 0);
      e = m_pend_valid ? 1'b1 : ($urandom_range(0, 4) != 0);
      l = e && ($urandom_range(0, 39) == 0);
      d = DIV_W'($urandom_range(0, 6));
      f = FRAC_W'($urandom);
      s = !m_pend_valid && ($urandom_range(0, 199) == 0);
      applyStimulus(e, l, d, f, s, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
